wbuf_fetch_ctrl: RTL and testbench

- Read initiator for the 12-bank read-only weight buffer (WBUF) subsystem.
- On a start command it issues a run of 4-lane bank reads: `bank_sel`, `addr_sel` and `en_sel` go to the WBUF, and returned `dout_sel` words come back after a fixed 1-cycle latency.
- Returned data is buffered in a small FIFO and presented to the MAC datapath as a valid/ready stream.
- Reads are flow-controlled by FIFO credits, so downstream backpressure never drops a beat.

---
 rtl/wbuf_fetch_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_wbuf_fetch_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbuf_fetch_ctrl.sv
// rtl/wbuf_fetch_ctrl.sv - credit-flow-controlled 4-lane WBUF read initiator with return FIFO and stream output
module wbuf_fetch_ctrl #(
  parameter int N_BANK     = 12,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 256,
  parameter int LEN_W      = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int BSEL_W     = $clog2(N_BANK),
  parameter int GRP_W      = ((N_BANK / 4) > 1) ? $clog2(N_BANK / 4) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [GRP_W-1:0]              cfg_bank_grp,
  input  logic [ADDR_W-1:0]             cfg_addr_base,
  input  logic [LEN_W-1:0]              cfg_len,
  input  logic [3:0]                    cfg_lane_mask,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [3:0][BSEL_W-1:0]        bank_sel,
  output logic [3:0][ADDR_W-1:0]        addr_sel,
  output logic [3:0]                    en_sel,
  input  logic [3:0][DATA_W-1:0]        dout_sel,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [3:0][DATA_W-1:0]        m_data,
  output logic                          m_last
);

  localparam int N_GRP = N_BANK / 4;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [GRP_W-1:0]    grp_q, grp_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [3:0]          mask_q, mask_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [LEN_W-1:0]    popped_q, popped_d;
  logic                rd_pend_q, rd_pend_d;
  logic                last_pend_q, last_pend_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fifo_count_q, fifo_count_d;

  // Return buffer storage; not reset because the head is gated by m_valid
  logic [3:0][DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic                   fifo_last_q [FIFO_DEPTH];

  logic                   credit_ok;
  logic                   issue_fire;
  logic                   push;
  logic                   pop;
  logic                   head_last;
  logic [3:0][DATA_W-1:0] push_data;

  // Credit uses the count before any same-cycle pop, counting the read in flight
  assign credit_ok  = (int'(fifo_count_q) + int'(rd_pend_q)) < FIFO_DEPTH;
  assign issue_fire = (state_q == FETCH) && (issued_q < len_q) && credit_ok;
  assign push       = rd_pend_q;
  assign m_valid    = (fifo_count_q != '0);
  assign pop        = m_valid && m_ready;
  assign head_last  = fifo_last_q[rd_ptr_q];
  assign m_data     = m_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_last     = m_valid && head_last;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;

  // Bank read request, driven only in a cycle that issues a beat
  always_comb begin
    bank_sel = '0;
    addr_sel = '0;
    en_sel   = '0;
    if (issue_fire) begin
      en_sel = mask_q;
      for (int j = 0; j < 4; j++) begin
        bank_sel[j] = BSEL_W'({grp_q, 2'(j)});
        addr_sel[j] = base_q + ADDR_W'(issued_q);
      end
    end
  end

  // Disabled lanes are forced to zero on the way into the buffer
  always_comb begin
    push_data = '0;
    for (int j = 0; j < 4; j++) begin
      push_data[j] = mask_q[j] ? dout_sel[j] : '0;
    end
  end

  // Command acceptance, FSM sequencing, counters and FIFO pointer updates
  always_comb begin
    state_d      = state_q;
    grp_d        = grp_q;
    base_d       = base_q;
    len_d        = len_q;
    mask_d       = mask_q;
    issued_d     = issued_q;
    popped_d     = popped_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    rd_pend_d    = issue_fire;
    last_pend_d  = issue_fire && (issued_q == (len_q - LEN_W'(1)));
    wr_ptr_d     = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d     = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
    if (pop) begin
      popped_d = popped_q + LEN_W'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (int'(cfg_bank_grp) >= N_GRP) begin
            err_d = 1'b1;
          end else if (cfg_len == '0) begin
            done_d = 1'b1;
          end else begin
            grp_d    = cfg_bank_grp;
            base_d   = cfg_addr_base;
            len_d    = cfg_len;
            mask_d   = cfg_lane_mask;
            issued_d = '0;
            popped_d = '0;
            state_d  = FETCH;
          end
        end
      end
      FETCH: begin
        if (issue_fire) begin
          issued_d = issued_q + LEN_W'(1);
          if (issued_q == (len_q - LEN_W'(1))) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grp_q        <= '0;
      base_q       <= '0;
      len_q        <= '0;
      mask_q       <= '0;
      issued_q     <= '0;
      popped_q     <= '0;
      rd_pend_q    <= 1'b0;
      last_pend_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grp_q        <= grp_d;
      base_q       <= base_d;
      len_q        <= len_d;
      mask_q       <= mask_d;
      issued_q     <= issued_d;
      popped_q     <= popped_d;
      rd_pend_q    <= rd_pend_d;
      last_pend_q  <= last_pend_d;
      done_q       <= done_d;
      err_q        <= err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // Capture returned bank data one cycle after the request
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_last_q[wr_ptr_q] <= last_pend_q;
    end
  end

endmodule

// File: tb/tb_wbuf_fetch_ctrl.sv
// tb/tb_wbuf_fetch_ctrl.sv - scoreboard bench for wbuf_fetch_ctrl with a WBUF read model
module tb_wbuf_fetch_ctrl;

  localparam int N_BANK     = 12;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 256;
  localparam int LEN_W      = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int BSEL_W     = 4;
  localparam int GRP_W      = 2;

  typedef struct {
    logic [3:0][BSEL_W-1:0] bank;
    logic [3:0][ADDR_W-1:0] addr;
    logic [3:0]             en;
  } req_t;

  typedef struct {
    logic [3:0][DATA_W-1:0] data;
    logic                   last;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [GRP_W-1:0]       cfg_bank_grp;
  logic [ADDR_W-1:0]      cfg_addr_base;
  logic [LEN_W-1:0]       cfg_len;
  logic [3:0]             cfg_lane_mask;
  logic                   busy, done, err;
  logic [3:0][BSEL_W-1:0] bank_sel;
  logic [3:0][ADDR_W-1:0] addr_sel;
  logic [3:0]             en_sel;
  logic [3:0][DATA_W-1:0] dout_sel;
  logic                   m_valid, m_ready, m_last;
  logic [3:0][DATA_W-1:0] m_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int issue_cnt = 0;
  int first_issue_cyc = 0;
  int last_issue_cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int last_pop_cyc = 0;
  logic prev_stall = 1'b0;
  logic [3:0][DATA_W-1:0] prev_data;
  logic prev_last;

  req_t  req_q[$];
  beat_t exp_q[$];

  wbuf_fetch_ctrl #(
    .N_BANK(N_BANK), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .FIFO_DEPTH(FIFO_DEPTH), .BSEL_W(BSEL_W), .GRP_W(GRP_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_bank_grp(cfg_bank_grp), .cfg_addr_base(cfg_addr_base),
    .cfg_len(cfg_len), .cfg_lane_mask(cfg_lane_mask),
    .busy(busy), .done(done), .err(err),
    .bank_sel(bank_sel), .addr_sel(addr_sel), .en_sel(en_sel),
    .dout_sel(dout_sel),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] wword(input int bank, input int addr);
    logic [DATA_W-1:0] w;
    for (int k = 0; k < DATA_W / 32; k++) begin
      w[k*32 +: 32] = 32'h5A00_0000 ^ (32'(bank) << 20) ^ (32'(addr) << 4) ^ 32'(k);
    end
    return w;
  endfunction

  // WBUF model: one-cycle read latency, disabled lanes return zero
  always @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      dout_sel[j] <= en_sel[j] ? wword(int'(bank_sel[j]), int'(addr_sel[j])) : '0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Request, return and stream monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (en_sel != '0) begin
        if (issue_cnt == 0) first_issue_cyc = cyc;
        last_issue_cyc = cyc;
        issue_cnt++;
        if (req_q.size() == 0) begin
          chk("req_unexpected", 64'(1), 64'(0));
        end else begin
          req_t r;
          r = req_q.pop_front();
          chk("req_bank", 64'(bank_sel), 64'(r.bank));
          chk("req_addr", 64'(addr_sel), 64'(r.addr));
          chk("req_en", 64'(en_sel), 64'(r.en));
        end
      end else if (busy) begin
        chk("noreq_bank", 64'(bank_sel), 64'(0));
        chk("noreq_addr", 64'(addr_sel), 64'(0));
      end
      if (dut.rd_pend_q) begin
        chk("push_when_full", 64'(dut.fifo_count_q == FIFO_DEPTH), 64'(0));
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(m_valid), 64'(1));
        chk("stall_last", 64'(m_last), 64'(prev_last));
        for (int j = 0; j < 4; j++) chk_w("stall_data", m_data[j], prev_data[j]);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 64'(1), 64'(0));
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          for (int j = 0; j < 4; j++) chk_w("beat_data", m_data[j], b.data[j]);
          chk("beat_last", 64'(m_last), 64'(b.last));
          if (m_last) last_pop_cyc = cyc;
        end
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // Queue the expected requests and beats, then pulse start
  task automatic run(input int grp, input int base, input int len, input logic [3:0] mask);
    for (int i = 0; i < len; i++) begin
      req_t  r;
      beat_t b;
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(base + i);
      for (int j = 0; j < 4; j++) begin
        r.bank[j] = BSEL_W'(grp * 4 + j);
        r.addr[j] = a;
        b.data[j] = mask[j] ? wword(grp * 4 + j, int'(a)) : '0;
      end
      r.en   = mask;
      b.last = (i == len - 1);
      req_q.push_back(r);
      exp_q.push_back(b);
    end
    issue_cnt = 0;
    @(posedge clk); #1;
    cfg_bank_grp  = GRP_W'(grp);
    cfg_addr_base = ADDR_W'(base);
    cfg_len       = LEN_W'(len);
    cfg_lane_mask = mask;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input string tag);
    bit found = 0;
    int dcyc = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #1;
      if (done) begin
        found = 1;
        dcyc = cyc;
      end
    end
    chk({tag, "_done_seen"}, 64'(found), 64'(1));
    if (found) begin
      chk({tag, "_done_lat"}, 64'(dcyc), 64'(last_pop_cyc + 1));
      chk({tag, "_busy_low"}, 64'(busy), 64'(0));
    end
    chk({tag, "_req_left"}, 64'(req_q.size()), 64'(0));
    chk({tag, "_beat_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
    chk({tag, "_en"}, 64'(en_sel), 64'(0));
    chk({tag, "_bank"}, 64'(bank_sel), 64'(0));
    chk({tag, "_addr"}, 64'(addr_sel), 64'(0));
    chk({tag, "_valid"}, 64'(m_valid), 64'(0));
    chk({tag, "_last"}, 64'(m_last), 64'(0));
    for (int j = 0; j < 4; j++) chk_w({tag, "_data"}, m_data[j], '0);
  endtask

  initial begin
    int d0, e0;
    rst = 1'b1;
    start = 1'b0;
    cfg_bank_grp = '0;
    cfg_addr_base = '0;
    cfg_len = '0;
    cfg_lane_mask = '0;
    m_ready = 1'b1;
    dout_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Basic run: group 1, three beats back to back
    run(1, 'h010, 3, 4'hF);
    wait_done("basic");
    chk("basic_issues", 64'(issue_cnt), 64'(3));
    chk("basic_consec", 64'(last_issue_cyc - first_issue_cyc), 64'(2));

    // Address wrap at the top of the bank
    run(0, 'h3FE, 4, 4'hF);
    wait_done("wrap");
    chk("wrap_issues", 64'(issue_cnt), 64'(4));

    // Backpressure: only the credit window is issued while stalled
    m_ready = 1'b0;
    run(2, 'h100, 8, 4'hF);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_issues_stalled", 64'(issue_cnt), 64'(FIFO_DEPTH));
    chk("bp_en_idle", 64'(en_sel), 64'(0));
    chk("bp_valid", 64'(m_valid), 64'(1));
    m_ready = 1'b1;
    wait_done("bp");
    chk("bp_issues", 64'(issue_cnt), 64'(8));

    // Lane mask: lanes 1 and 3 disabled
    run(1, 'h200, 2, 4'b0101);
    wait_done("mask");

    // Zero-length command
    d0 = done_cnt;
    issue_cnt = 0;
    @(posedge clk); #1;
    cfg_bank_grp = 2'd0; cfg_len = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zlen_done", 64'(done), 64'(1));
    chk("zlen_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    chk("zlen_done_pulse", 64'(done), 64'(0));
    chk("zlen_issues", 64'(issue_cnt), 64'(0));

    // Invalid bank group
    e0 = err_cnt;
    @(posedge clk); #1;
    cfg_bank_grp = 2'd3; cfg_len = LEN_W'(4); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("grp_err", 64'(err), 64'(1));
    chk("grp_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    chk("grp_err_pulse", 64'(err), 64'(0));
    chk("grp_issues", 64'(issue_cnt), 64'(0));
    chk("grp_err_cnt", 64'(err_cnt - e0), 64'(1));

    // Start while busy is ignored
    d0 = done_cnt;
    e0 = err_cnt;
    run(2, 'h040, 4, 4'hF);
    cfg_bank_grp = 2'd3; cfg_len = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start");
    repeat (3) @(posedge clk);
    #1;
    chk("busy_start_done_cnt", 64'(done_cnt - d0), 64'(1));
    chk("busy_start_err_cnt", 64'(err_cnt - e0), 64'(0));
    chk("busy_start_issues", 64'(issue_cnt), 64'(4));

    // Reset mid-run with beats buffered
    m_ready = 1'b0;
    run(2, 'h080, 6, 4'hF);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_buffered", 64'(m_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    req_q.delete();
    exp_q.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done_cnt - d0), 64'(0));
    chk("midrst_idle", 64'(busy), 64'(0));
    run(2, 'h080, 3, 4'hF);
    wait_done("post_rst");
    chk("post_rst_issues", 64'(issue_cnt), 64'(3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
